// File: rtl/mux8_scan_ctrl_pkg.sv
// Shared encodings and types for the 8x1 mux scan sequencer.
// Pure declarations; no timing or flow-control behaviour of its own.
package mux8_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef logic [2:0] chan_t;

    localparam logic  MODE_FULL   = 1'b0;
    localparam logic  MODE_SINGLE = 1'b1;
    localparam chan_t LAST_CHAN   = 3'd7;

    // A scan ends after a single-mode sample or after the last channel of a full scan.
    function automatic logic scan_ends(input logic mode_q, input chan_t sel);
        return (mode_q == MODE_SINGLE) || (sel == LAST_CHAN);
    endfunction

endpackage

// File: rtl/mux8_scan_ctrl_if.sv
// Request/select/result bundle between a scan requester, the 8x1 mux and the sequencer.
// Wiring only; start is a level request honoured only while the sequencer is idle.
interface mux8_scan_ctrl_if;
    import mux8_scan_ctrl_pkg::*;

    logic        start;
    logic        mode;
    chan_t       chan;
    logic        s1;
    logic        s2;
    logic        s3;
    logic        mux_o;
    logic        busy;
    logic        done;
    logic [7:0]  result;

    modport slave (
        input  start, mode, chan, mux_o,
        output s1, s2, s3, busy, done, result
    );

    modport master (
        output start, mode, chan,
        input  s1, s2, s3, mux_o, busy, done, result
    );

endinterface

// File: rtl/mux8_scan_ctrl_settle_timer.sv
// Settle counter: counts enabled cycles from a clear and flags the last settle cycle.
// expire is combinational off the count; clear has priority over enable.
module settle_timer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == LAST_CNT);

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Drives the 8x1 mux selects, settles each channel, then samples it into result.
// Single scan: done at start+S+2; full scan: start+1+8(S+1); start ignored while busy or in DONE.
module mux8_scan_ctrl
    import mux8_scan_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux8_scan_ctrl_if.slave  bus
);

    state_t     state;
    chan_t      sel;
    logic       mode_q;
    logic [7:0] result_q;
    logic       busy_q;
    logic       done_q;

    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_expire;

    // The counter restarts from zero on every entry into SETTLE.
    assign tmr_clr = (state == ST_IDLE) || (state == ST_SAMPLE);
    assign tmr_en  = (state == ST_SETTLE);

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sel      <= '0;
            mode_q   <= MODE_FULL;
            result_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        sel    <= (bus.mode == MODE_SINGLE) ? bus.chan : chan_t'(0);
                        busy_q <= 1'b1;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expire) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // Selects advance only at the closing edge, so the sampled channel is stable.
                    result_q[sel] <= bus.mux_o;
                    if (scan_ends(mode_q, sel)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        sel   <= sel + 3'd1;
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s1     = sel[2];
    assign bus.s2     = sel[1];
    assign bus.s3     = sel[0];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench: two sequencers (settle 1 and 3) each feeding a behavioural 8x1 mux.
// Cycle numbers are relative to the edge that samples start (that edge is cycle k).
module tb_mux8_scan_ctrl;
    import mux8_scan_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux8_scan_ctrl_if b1 ();
    mux8_scan_ctrl_if b2 ();

    logic [7:0] in1;
    logic [7:0] in2;

    // Mux: input n (a=0 .. h=7) is routed out when {s1,s2,s3} = n.
    assign b1.mux_o = in1[{b1.s1, b1.s2, b1.s3}];
    assign b2.mux_o = in2[{b2.s1, b2.s2, b2.s3}];

    mux8_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    mux8_scan_ctrl #(.SETTLE_CYCLES(3), .CNT_W(4)) u_dut3 (.clk(clk), .rst(rst), .bus(b2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] sel_of(input bit u2);
        return u2 ? {b2.s1, b2.s2, b2.s3} : {b1.s1, b1.s2, b1.s3};
    endfunction

    task automatic set_start(input bit u2, input logic v);
        if (u2) b2.start = v;
        else    b1.start = v;
    endtask

    // Issue a request and watch `win` cycles; d1/d2 are the relative cycles of the first two dones.
    task automatic run(input bit u2, input logic m, input logic [2:0] ch, input int win,
                       input int inj, input bit hold,
                       output int d1, output int d2, output int nd, output logic [2:0] last_sel);
        int k;
        int rel;
        int c_step;
        logic [2:0] prev;
        logic [2:0] cur;
        logic dn;
        logic bz;
        @(negedge clk);
        set_start(u2, 1'b1);
        if (u2) begin b2.mode = m; b2.chan = ch; end
        else    begin b1.mode = m; b1.chan = ch; end
        @(posedge clk);
        #1 k = cyc;
        d1 = -1; d2 = -1; nd = 0; c_step = 0; prev = 3'd0;
        for (int i = 1; i <= win; i++) begin
            @(negedge clk);
            if (i == 1 && !hold) set_start(u2, 1'b0);
            if (i == inj)        set_start(u2, 1'b1);
            if (i == inj + 1 && inj > 0) set_start(u2, 1'b0);
            rel = cyc - k + 1;
            cur = sel_of(u2);
            dn  = u2 ? b2.done : b1.done;
            bz  = u2 ? b2.busy : b1.busy;
            // Channel c glitches during its first settle cycle, then holds 0.
            if (u2 && cur == 3'd2 && bz) begin
                c_step++;
                in2[2] = (c_step == 1);
            end
            if (i == 1) begin
                check("sel_first", {29'd0, cur}, (m == MODE_SINGLE) ? {29'd0, ch} : 32'd0);
                prev = cur;
            end else if (!hold && cur != prev) begin
                check("sel_step", {29'd0, cur}, {29'd0, prev} + 32'd1);
                prev = cur;
            end
            if (dn) begin
                nd++;
                if (nd == 1) d1 = rel;
                else if (nd == 2) d2 = rel;
                check("busy_at_done", {31'd0, bz}, 32'd0);
            end
        end
        if (hold) set_start(u2, 1'b0);
        last_sel = prev;
    endtask

    initial begin
        int d1;
        int d2;
        int nd;
        int found;
        logic [2:0] ls;

        rst = 1'b1;
        b1.start = 1'b0; b1.mode = 1'b0; b1.chan = 3'd0;
        b2.start = 1'b0; b2.mode = 1'b0; b2.chan = 3'd0;
        in1 = 8'h4D;
        in2 = 8'h49;
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, b1.busy}, 32'd0);
        check("rst_done",   {31'd0, b1.done}, 32'd0);
        check("rst_sel",    {29'd0, sel_of(1'b0)}, 32'd0);
        check("rst_result", {24'd0, b1.result}, 32'h00);
        check("rst_result3", {24'd0, b2.result}, 32'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full scan, settle 1.
        run(1'b0, MODE_FULL, 3'd0, 21, 0, 1'b0, d1, d2, nd, ls);
        check("full_lat",    d1, 17);
        check("full_ndone",  nd, 1);
        check("full_result", {24'd0, b1.result}, 32'h4D);
        check("full_lastsel", {29'd0, ls}, 32'd7);

        // Single channel 5 with f=1.
        in1[5] = 1'b1;
        run(1'b0, MODE_SINGLE, 3'd5, 7, 0, 1'b0, d1, d2, nd, ls);
        check("single_lat",    d1, 3);
        check("single_ndone",  nd, 1);
        check("single_result", {24'd0, b1.result}, 32'h6D);
        check("single_sel",    {29'd0, sel_of(1'b0)}, 32'd5);

        // start pulsed mid-scan is ignored.
        in1 = 8'h4D;
        run(1'b0, MODE_FULL, 3'd0, 22, 6, 1'b0, d1, d2, nd, ls);
        check("busy_start_lat",    d1, 17);
        check("busy_start_ndone",  nd, 1);
        check("busy_start_result", {24'd0, b1.result}, 32'h4D);

        // Reset during settle of channel 4.
        @(negedge clk);
        b1.start = 1'b1; b1.mode = MODE_FULL;
        @(negedge clk);
        b1.start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (sel_of(1'b0) == 3'd4 && b1.busy) found = 1;
            else @(negedge clk);
        end
        check("rst_reach_ch4", found, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   {31'd0, b1.busy}, 32'd0);
        check("arst_sel",    {29'd0, sel_of(1'b0)}, 32'd0);
        check("arst_result", {24'd0, b1.result}, 32'h00);
        nd = 0;
        repeat (3) begin @(negedge clk); if (b1.done) nd++; end
        rst = 1'b0;
        repeat (20) begin @(negedge clk); if (b1.done) nd++; end
        check("arst_no_done", nd, 0);
        check("arst_result_hold", {24'd0, b1.result}, 32'h00);
        run(1'b0, MODE_FULL, 3'd0, 21, 0, 1'b0, d1, d2, nd, ls);
        check("post_rst_lat",    d1, 17);
        check("post_rst_result", {24'd0, b1.result}, 32'h4D);

        // Settle 3, channel c glitches during settle.
        run(1'b1, MODE_FULL, 3'd0, 37, 0, 1'b0, d1, d2, nd, ls);
        check("s3_lat",    d1, 33);
        check("s3_ndone",  nd, 1);
        check("s3_result", {24'd0, b2.result}, 32'h49);

        // start held high: back-to-back scans one cycle apart from latency.
        run(1'b0, MODE_FULL, 3'd0, 40, 0, 1'b1, d1, d2, nd, ls);
        check("hold_d1",    d1, 17);
        check("hold_d2",    d2, 35);
        check("hold_ndone", nd, 2);
        repeat (30) @(negedge clk);
        check("hold_result", {24'd0, b1.result}, 32'h4D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
        $fatal(1);
    end

endmodule
